serial_add_ctrl: RTL and testbench

- Bit-serial sequencer that performs a WIDTH-bit addition using one instance of the team's existing 1-bit full-adder cell `adder`.
- Operates over WIDTH clock cycles: latches the operands, feeds one bit pair per cycle with a registered carry, collects the sum, then signals completion.
- Sits between a requester issuing start/operands and the shared full-adder resource.
- Trades area for latency in small arithmetic datapaths.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/adder.sv | 14 +
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and defaults for the bit-serial adder sequencer
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 1-bit full-adder cell
module adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  // combinational sum and majority carry
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder sequencer around one full-adder cell; optional SERIAL_ADD_OVF_EN adds signed overflow output ovf
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = SERIAL_ADD_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_co;
  logic             fa_s;

  // the single shared full-adder sees the current LSB pair and the registered carry
  adder u_adder (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .co (fa_co),
    .s  (fa_s)
  );

  // sequencer: operand capture, one bit per cycle, then a one-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry entering the MSB differs from carry leaving it on signed overflow
            ovf   <= carry ^ fa_co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH=8), ovf cases under SERIAL_ADD_OVF_EN
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int checks;
  int errors;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never overlap
  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_done_overlap busy=%0b done=%0b required not both 1", busy, done);
    end
  end

  // issue one start, scramble operands afterwards, wait for done (bounded)
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state busy=%0b done=%0b sum=%h cout=%0b required all 0", busy, done, sum, cout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_op(8'h35, 8'h4A, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency got %0d required 9", lat);
    end
    checks++;
    if (bcnt !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d required 8", bcnt);
    end
    checks++;
    if (sum !== 8'h7F || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result sum=%h cout=%0b required 7f 0", sum, cout);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle done=%0b required 0", done);
    end
  endtask

  task automatic test_carry();
    int lat, bcnt;
    run_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 9 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_wrap lat=%0d sum=%h cout=%0b required 9 00 1", lat, sum, cout);
    end
    run_op(8'hFF, 8'hFF, 1'b1, lat, bcnt);
    checks++;
    if (lat !== 9 || sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_max lat=%0d sum=%h cout=%0b required 9 ff 1", lat, sum, cout);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL result_hold sum=%h cout=%0b required ff 1", sum, cout);
    end
  endtask

  task automatic test_ignore_start();
    int done_at;
    @(negedge clk);
    a = 8'h21; b = 8'h13; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    done_at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) begin
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
      if (i == 9) begin
        checks++;
        if (done !== 1'b1 || sum !== 8'h35 || cout !== 1'b0) begin
          errors++;
          $display("FAIL ignore_first_result done=%0b sum=%h cout=%0b required 1 35 0", done, sum, cout);
        end
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      end
      if (i == 10) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h35) begin
          errors++;
          $display("FAIL ignore_done_start busy=%0b done=%0b sum=%h required 0 0 35", busy, done, sum);
        end
        a = 8'h0F; b = 8'hF1; cin = 1'b0; start = 1'b1;
      end
      if (i == 11) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL accept_after_done busy=%0b required 1", busy);
        end
        start = 1'b0;
      end
      if (i > 11 && done === 1'b1) begin
        done_at = i;
        break;
      end
    end
    checks++;
    if (done_at !== 19 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL second_op done_at=%0d sum=%h cout=%0b required 19 00 1", done_at, sum, cout);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat, bcnt;
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before busy=%0b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL abort_async busy=%0b done=%0b sum=%h cout=%0b required all 0", busy, done, sum, cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done activity=%0d required 0", seen);
    end
    run_op(8'h12, 8'h34, 1'b1, lat, bcnt);
    checks++;
    if (lat !== 9 || sum !== 8'h47 || cout !== 1'b0) begin
      errors++;
      $display("FAIL after_abort lat=%0d sum=%h cout=%0b required 9 47 0", lat, sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    int hits[3];
    int n;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    n = 0;
    for (int i = 1; i <= 35 && n < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        hits[n] = i;
        n++;
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result pulse=%0d sum=%h cout=%0b required 30 0", n, sum, cout);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 3 || hits[0] !== 9 || hits[1] !== 19 || hits[2] !== 29) begin
      errors++;
      $display("FAIL b2b_spacing pulses=%0d at %0d %0d %0d required 3 at 9 19 29", n, hits[0], hits[1], hits[2]);
    end
    repeat (12) @(negedge clk);
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    int lat, bcnt;
    run_op(8'h7F, 8'h01, 1'b0, lat, bcnt);
    checks++;
    if (sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos sum=%h cout=%0b ovf=%0b required 80 0 1", sum, cout, ovf);
    end
    run_op(8'h80, 8'h80, 1'b0, lat, bcnt);
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg sum=%h cout=%0b ovf=%0b required 00 1 1", sum, cout, ovf);
    end
    run_op(8'h05, 8'hFB, 1'b0, lat, bcnt);
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none sum=%h cout=%0b ovf=%0b required 00 1 0", sum, cout, ovf);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
